// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, redirect/stall arbitration and the IF/ID pipeline register.
// A small BOOT/RUN/HALTED controller sequences start-up and permanent halt.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        Halt,
   input  logic [31:0] Instruction,
   output logic [31:0] IMemAddress,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid,
   output logic        AlignFault,
   output logic [31:0] FetchCount
);

   localparam logic [31:0] ResetPcWord = {RESET_PC[31:2], 2'b00};

   typedef enum logic [1:0] {StBoot, StRun, StHalted} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic        valid_q, valid_d;
   logic        fault_q, fault_d;
   logic [31:0] count_q, count_d;

   logic [31:0] pc_plus4;
   logic        redirect;
   logic [31:0] target;

   assign pc_plus4 = pc_q + 32'd4;
   assign redirect = BranchTaken | Jump;
   // Branch resolves later in the pipe than a decode-stage jump, so it wins.
   assign target   = BranchTaken ? BranchTarget : JumpTarget;

   // State register and datapath registers
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= StBoot;
         pc_q    <= ResetPcWord;
         instr_q <= 32'h0;
         pc4_q   <= 32'h0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         count_q <= 32'h0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StBoot:   state_d = Halt ? StHalted : StRun;
         StRun:    if (Halt) state_d = StHalted;
         StHalted: state_d = StHalted;
         default:  state_d = StBoot;
      endcase
   end

   // Datapath next values; every non-advancing, non-stalled edge loads a bubble
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      fault_d = fault_q;
      count_d = count_q;
      unique case (state_q)
         StRun: begin
            if (Halt) begin
               instr_d = 32'h0;
               pc4_d   = 32'h0;
               valid_d = 1'b0;
            end else if (redirect) begin
               pc_d    = {target[31:2], 2'b00};
               instr_d = 32'h0;
               pc4_d   = 32'h0;
               valid_d = 1'b0;
               if (target[1:0] != 2'b00) fault_d = 1'b1;
            end else if (!Stall) begin
               pc_d    = pc_plus4;
               instr_d = Instruction;
               pc4_d   = pc_plus4;
               valid_d = 1'b1;
               count_d = count_q + 32'd1;
            end
         end
         StBoot: begin
            pc_d    = ResetPcWord;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
         end
         default: begin
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign IMemAddress       = pc_q;
   assign IF_ID_Instruction = instr_q;
   assign IF_ID_PCPlus4     = pc4_q;
   assign IF_ID_Valid       = valid_q;
   assign AlignFault        = fault_q;
   assign FetchCount        = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model pushes expected IF/ID state per edge,
// which is popped and compared after the edge, plus directed constant checks.
module tb_fetch_stage;

   localparam logic [31:0] ResetPc = 32'h00000000;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Stall, BranchTaken, Jump, Halt;
   logic [31:0] BranchTarget, JumpTarget;
   logic [31:0] Instruction;
   logic [31:0] IMemAddress, IF_ID_Instruction, IF_ID_PCPlus4, FetchCount;
   logic        IF_ID_Valid, AlignFault;

   fetch_stage #(.RESET_PC(ResetPc)) dut (
      .Clk              (Clk),
      .Rst              (Rst),
      .Stall            (Stall),
      .BranchTaken      (BranchTaken),
      .BranchTarget     (BranchTarget),
      .Jump             (Jump),
      .JumpTarget       (JumpTarget),
      .Halt             (Halt),
      .Instruction      (Instruction),
      .IMemAddress      (IMemAddress),
      .IF_ID_Instruction(IF_ID_Instruction),
      .IF_ID_PCPlus4    (IF_ID_PCPlus4),
      .IF_ID_Valid      (IF_ID_Valid),
      .AlignFault       (AlignFault),
      .FetchCount       (FetchCount)
   );

   always #5 Clk = ~Clk;

   // Memory word i holds i*4, i.e. each word's content equals its byte address.
   function automatic logic [31:0] imem(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

   assign Instruction = imem(IMemAddress);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] count;
      logic        valid;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: 0 = boot, 1 = run, 2 = halted
   int          m_state;
   logic [31:0] m_pc, m_instr, m_pc4, m_count;
   logic        m_valid, m_fault;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pc    = ResetPc;
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_count = 32'h0;
      m_valid = 1'b0;
      m_fault = 1'b0;
   endtask

   task automatic clear_inputs();
      Stall        = 1'b0;
      BranchTaken  = 1'b0;
      Jump         = 1'b0;
      Halt         = 1'b0;
      BranchTarget = 32'h0;
      JumpTarget   = 32'h0;
   endtask

   // Asynchronous reset pulse, checked before any clock edge can occur.
   task automatic do_reset(input string tag);
      Rst = 1'b1;
      #1;
      check({tag, "_rst_pc"}, IMemAddress, ResetPc);
      check({tag, "_rst_instr"}, IF_ID_Instruction, 32'h0);
      check({tag, "_rst_pc4"}, IF_ID_PCPlus4, 32'h0);
      check({tag, "_rst_valid"}, {31'h0, IF_ID_Valid}, 32'h0);
      check({tag, "_rst_fault"}, {31'h0, AlignFault}, 32'h0);
      check({tag, "_rst_count"}, FetchCount, 32'h0);
      model_reset();
      #2;
      Rst = 1'b0;
   endtask

   task automatic bubble();
      m_instr = 32'h0;
      m_pc4   = 32'h0;
      m_valid = 1'b0;
   endtask

   // Predict one edge from the current inputs, then let the DUT take it and compare.
   task automatic step(input string tag);
      logic [31:0] tgt;
      exp_t e, got;
      if (m_state == 2) begin
         bubble();
      end else if (m_state == 0) begin
         bubble();
         m_state = Halt ? 2 : 1;
      end else if (Halt) begin
         bubble();
         m_state = 2;
      end else if (BranchTaken || Jump) begin
         tgt = BranchTaken ? BranchTarget : JumpTarget;
         m_pc = tgt & 32'hFFFF_FFFC;
         if (tgt[1:0] != 2'b00) m_fault = 1'b1;
         bubble();
      end else if (!Stall) begin
         m_instr = imem(m_pc);
         m_pc4   = m_pc + 32'd4;
         m_valid = 1'b1;
         m_count = m_count + 32'd1;
         m_pc    = m_pc + 32'd4;
      end
      e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4;
      e.count = m_count; e.valid = m_valid; e.fault = m_fault;
      exp_q.push_back(e);
      @(posedge Clk);
      #1;
      got = exp_q.pop_front();
      check({tag, "_pc"}, IMemAddress, got.pc);
      check({tag, "_instr"}, IF_ID_Instruction, got.instr);
      check({tag, "_pc4"}, IF_ID_PCPlus4, got.pc4);
      check({tag, "_valid"}, {31'h0, IF_ID_Valid}, {31'h0, got.valid});
      check({tag, "_fault"}, {31'h0, AlignFault}, {31'h0, got.fault});
      check({tag, "_count"}, FetchCount, got.count);
   endtask

   initial begin
      clear_inputs();
      do_reset("init");

      // Start-up: bubble, then words 0,4,8
      step("boot");
      check("boot_valid_low", {31'h0, IF_ID_Valid}, 32'h0);
      for (int i = 0; i < 3; i++) step("seq");
      check("seq_instr", IF_ID_Instruction, 32'h8);
      check("seq_pc4", IF_ID_PCPlus4, 32'hC);
      check("seq_count", FetchCount, 32'd3);

      // Stall at 0x10
      step("to10");
      check("at10", IMemAddress, 32'h10);
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) step("stall");
      check("stall_pc", IMemAddress, 32'h10);
      check("stall_count", FetchCount, 32'd4);
      Stall = 1'b0;
      step("unstall");
      check("unstall_pc", IMemAddress, 32'h14);

      // Branch beats jump and stall
      Jump = 1'b1; JumpTarget = 32'h20;
      step("j20");
      clear_inputs();
      Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h100;
      Jump = 1'b1; JumpTarget = 32'h200;
      step("prio");
      check("prio_pc", IMemAddress, 32'h100);
      check("prio_count", FetchCount, 32'd5);
      clear_inputs();
      step("after_prio");

      // Misaligned jump target
      Jump = 1'b1; JumpTarget = 32'h46;
      step("misalign");
      check("misalign_pc", IMemAddress, 32'h44);
      clear_inputs();
      for (int i = 0; i < 3; i++) step("sticky");
      check("sticky_fault", {31'h0, AlignFault}, 32'h1);

      // PC wrap
      do_reset("wrap");
      step("wrap_boot");
      Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
      step("wrap_j");
      clear_inputs();
      step("wrap_adv");
      check("wrap_pc", IMemAddress, 32'h0);
      check("wrap_pc4", IF_ID_PCPlus4, 32'h0);

      // Halt beats branch
      Jump = 1'b1; JumpTarget = 32'h30;
      step("j30");
      clear_inputs();
      step("at30");
      Halt = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h80;
      step("halt");
      check("halt_pc", IMemAddress, 32'h34);
      clear_inputs();
      for (int i = 0; i < 6; i++) begin
         Stall       = 1'($urandom_range(0, 1));
         BranchTaken = 1'($urandom_range(0, 1));
         Jump        = 1'($urandom_range(0, 1));
         BranchTarget = $urandom;
         JumpTarget   = $urandom;
         step("halted");
      end
      check("halted_valid", {31'h0, IF_ID_Valid}, 32'h0);
      clear_inputs();
      do_reset("from_halt");
      step("rehalt_boot");
      step("rehalt_run");

      // Halt at exactly 0x30 with a pending branch
      Jump = 1'b1; JumpTarget = 32'h2C;
      step("j2c");
      clear_inputs();
      step("to30");
      check("to30_pc", IMemAddress, 32'h30);
      Halt = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h100;
      step("halt30");
      check("halt30_pc", IMemAddress, 32'h30);
      clear_inputs();
      step("halt30_hold");

      // Halt while in BOOT
      do_reset("boothalt");
      Halt = 1'b1;
      step("boothalt_edge");
      clear_inputs();
      step("boothalt_hold");
      check("boothalt_count", FetchCount, 32'd0);

      // Randomised traffic, with a reset mid-stall and mid-redirect
      do_reset("rand");
      for (int i = 0; i < 80; i++) begin
         clear_inputs();
         Stall       = ($urandom_range(0, 3) == 0);
         BranchTaken = ($urandom_range(0, 7) == 0);
         Jump        = ($urandom_range(0, 7) == 0);
         BranchTarget = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         JumpTarget   = $urandom & (($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
         if (i == 30 || i == 55) do_reset("rand_mid");
         step("rand");
      end
      clear_inputs();
      Halt = 1'b1;
      step("rand_halt");
      clear_inputs();
      step("rand_halted");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
